// File: rtl/regfile_2w2r.sv
// Two-write / two-read register bank with reset-to-zero, optional bypass, optional zero reg and a clear engine.
// Latency: reads are combinational; writes are visible from storage one cycle after the edge (same cycle with bypass).
// Backpressure: none; writes presented while busy=1 are dropped, so upstream must hold off while busy is high.
module regfile_2w2r #(
   parameter int N        = 2,
   parameter int M        = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         we3,
   input  logic [N-1:0] a3,
   input  logic [M-1:0] d3,
   input  logic         we4,
   input  logic [N-1:0] a4,
   input  logic [M-1:0] d4,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] a2,
   output logic [M-1:0] d1,
   output logic [M-1:0] d2,
   input  logic         clr,
   output logic         busy,
   output logic         coll
);

   localparam int DEPTH = 2 ** N;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   cnt_q, cnt_d;
   logic           coll_q, coll_d;
   logic [M-1:0]   mem_q [DEPTH];
   logic [M-1:0]   mem_d [DEPTH];

   logic           same_addr;
   logic           w3_ok;
   logic           w4_ok;
   logic           zero_on;
   logic           byp_on;

   assign zero_on = (ZERO_REG != 0);
   assign byp_on  = (BYPASS != 0) && (state_q == IDLE);

   // Qualify writes: entry 0 is read-only when hardwired, and port 3 wins a same-address collision.
   always_comb begin
      same_addr = we3 && we4 && (a3 == a4);
      w3_ok     = we3 && !(zero_on && (a3 == '0));
      w4_ok     = we4 && !(zero_on && (a4 == '0)) && !same_addr;
   end

   // Next-state: normal writes in IDLE, one entry zeroed per cycle in CLEAR.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      coll_d  = 1'b0;
      mem_d   = mem_q;
      case (state_q)
         IDLE: begin
            if (w3_ok) mem_d[a3] = d3;
            if (w4_ok) mem_d[a4] = d4;
            // A collision on a hardwired zero entry has no observable effect, so it is not flagged.
            coll_d = same_addr && !(zero_on && (a3 == '0));
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == {N{1'b1}}) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, collision flag and storage; reset zeroes everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         coll_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coll_q  <= coll_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Read port 1: zero reg first, then forward from port 3, then port 4 (only if it is not overridden), else storage.
   always_comb begin
      d1 = mem_q[a1];
      if (zero_on && (a1 == '0)) begin
         d1 = '0;
      end else if (byp_on && we3 && (a3 == a1)) begin
         d1 = d3;
      end else if (byp_on && we4 && (a4 == a1) && !(we3 && (a3 == a4))) begin
         d1 = d4;
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      d2 = mem_q[a2];
      if (zero_on && (a2 == '0)) begin
         d2 = '0;
      end else if (byp_on && we3 && (a3 == a2)) begin
         d2 = d3;
      end else if (byp_on && we4 && (a4 == a2) && !(we3 && (a3 == a4))) begin
         d2 = d4;
      end
   end

   assign busy = (state_q == CLEAR);
   assign coll = coll_q;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: three instances (no bypass, bypass, bypass + zero reg) share one stimulus stream.
// Expected values are queued as stimulus is applied and compared at the following falling edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_2w2r;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       we3, we4, clr;
   logic [1:0] a1, a2, a3, a4;
   logic [3:0] d3, d4;

   logic [3:0] nb_d1, nb_d2, bp_d1, bp_d2, zr_d1, zr_d2;
   logic       nb_busy, bp_busy, zr_busy;
   logic       nb_coll, bp_coll, zr_coll;

   always #5 clk = ~clk;

   regfile_2w2r #(.N(2), .M(4), .BYPASS(0), .ZERO_REG(0)) u_nb (
      .clk(clk), .rst_n(rst_n),
      .we3(we3), .a3(a3), .d3(d3), .we4(we4), .a4(a4), .d4(d4),
      .a1(a1), .a2(a2), .d1(nb_d1), .d2(nb_d2),
      .clr(clr), .busy(nb_busy), .coll(nb_coll)
   );

   regfile_2w2r #(.N(2), .M(4), .BYPASS(1), .ZERO_REG(0)) u_bp (
      .clk(clk), .rst_n(rst_n),
      .we3(we3), .a3(a3), .d3(d3), .we4(we4), .a4(a4), .d4(d4),
      .a1(a1), .a2(a2), .d1(bp_d1), .d2(bp_d2),
      .clr(clr), .busy(bp_busy), .coll(bp_coll)
   );

   regfile_2w2r #(.N(2), .M(4), .BYPASS(1), .ZERO_REG(1)) u_zr (
      .clk(clk), .rst_n(rst_n),
      .we3(we3), .a3(a3), .d3(d3), .we4(we4), .a4(a4), .d4(d4),
      .a1(a1), .a2(a2), .d1(zr_d1), .d2(zr_d2),
      .clr(clr), .busy(zr_busy), .coll(zr_coll)
   );

   localparam int S_NB_D1 = 0, S_NB_D2 = 1, S_BP_D1 = 2, S_BP_D2 = 3;
   localparam int S_ZR_D1 = 4, S_ZR_D2 = 5, S_NB_BUSY = 6, S_BP_BUSY = 7;
   localparam int S_ZR_BUSY = 8, S_NB_COLL = 9, S_BP_COLL = 10, S_ZR_COLL = 11;
   localparam int S_CNT = 12;

   typedef struct {
      string tag;
      int    sig;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   busy_cnt = 0;

   function automatic int obs(input int sig);
      case (sig)
         S_NB_D1:   return int'(nb_d1);
         S_NB_D2:   return int'(nb_d2);
         S_BP_D1:   return int'(bp_d1);
         S_BP_D2:   return int'(bp_d2);
         S_ZR_D1:   return int'(zr_d1);
         S_ZR_D2:   return int'(zr_d2);
         S_NB_BUSY: return int'(nb_busy);
         S_BP_BUSY: return int'(bp_busy);
         S_ZR_BUSY: return int'(zr_busy);
         S_NB_COLL: return int'(nb_coll);
         S_BP_COLL: return int'(bp_coll);
         S_ZR_COLL: return int'(zr_coll);
         S_CNT:     return busy_cnt;
         default:   return -1;
      endcase
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic expect_val(input string tag, input int sig, input int val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.sig), e.val);
      end
   endtask

   // Compare queued expectations on the falling edge, then advance past the next rising edge.
   task automatic cyc();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      we3 = 1'b0; we4 = 1'b0; clr = 1'b0;
      a1 = '0; a2 = '0; a3 = '0; a4 = '0; d3 = '0; d4 = '0;
      #2;
      rst_n = 1'b0;

      // Reset is immediate: every address of every instance reads zero, flags low.
      for (int a = 0; a < 4; a++) begin
         a1 = 2'(a);
         a2 = 2'(3 - a);
         expect_val("rst_nb_d1", S_NB_D1, 0);
         expect_val("rst_nb_d2", S_NB_D2, 0);
         expect_val("rst_bp_d1", S_BP_D1, 0);
         expect_val("rst_bp_d2", S_BP_D2, 0);
         expect_val("rst_zr_d1", S_ZR_D1, 0);
         expect_val("rst_zr_d2", S_ZR_D2, 0);
         #1;
         drain();
      end
      expect_val("rst_busy_nb", S_NB_BUSY, 0);
      expect_val("rst_busy_bp", S_BP_BUSY, 0);
      expect_val("rst_busy_zr", S_ZR_BUSY, 0);
      expect_val("rst_coll_bp", S_BP_COLL, 0);
      expect_val("rst_coll_zr", S_ZR_COLL, 0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write then read: storage only updates after the edge; bypass shows it at once.
      we3 = 1'b1; a3 = 2'd2; d3 = 4'hA; a1 = 2'd2; a2 = 2'd2;
      expect_val("wr_nb_same", S_NB_D1, 0);
      expect_val("wr_bp_same", S_BP_D1, 'hA);
      cyc();
      we3 = 1'b0;
      expect_val("wr_nb_after", S_NB_D1, 'hA);
      expect_val("wr_bp_after", S_BP_D2, 'hA);
      cyc();

      // Bypass from port 4, then port 3 overriding it on the same address.
      we4 = 1'b1; a4 = 2'd1; d4 = 4'h5; a2 = 2'd1;
      expect_val("byp_d4", S_BP_D2, 5);
      expect_val("nob_d4", S_NB_D2, 0);
      expect_val("coll_idle", S_BP_COLL, 0);
      cyc();
      we3 = 1'b1; a3 = 2'd1; d3 = 4'h3;
      expect_val("byp_d3_wins", S_BP_D2, 3);
      expect_val("nob_stored", S_NB_D2, 5);
      cyc();
      we3 = 1'b0; we4 = 1'b0;
      expect_val("coll_bp", S_BP_COLL, 1);
      expect_val("coll_nb", S_NB_COLL, 1);
      expect_val("mem1_bp", S_BP_D2, 3);
      expect_val("mem1_nb", S_NB_D2, 3);
      cyc();
      expect_val("coll_pulse", S_BP_COLL, 0);
      cyc();

      // Hardwired zero register ignores writes and collisions on entry 0.
      we3 = 1'b1; a3 = 2'd0; d3 = 4'h9; we4 = 1'b1; a4 = 2'd0; d4 = 4'h6; a1 = 2'd0;
      expect_val("zr_same", S_ZR_D1, 0);
      expect_val("bp_a0_byp", S_BP_D1, 9);
      cyc();
      we3 = 1'b0; we4 = 1'b0;
      expect_val("zr_later", S_ZR_D1, 0);
      expect_val("zr_nocoll", S_ZR_COLL, 0);
      expect_val("bp_coll_a0", S_BP_COLL, 1);
      expect_val("bp_mem0", S_BP_D1, 9);
      cyc();

      // Clear engine: preload all entries with F.
      we3 = 1'b1; a3 = 2'd0; d3 = 4'hF; we4 = 1'b1; a4 = 2'd1; d4 = 4'hF;
      cyc();
      a3 = 2'd2; a4 = 2'd3;
      cyc();
      we3 = 1'b0; we4 = 1'b0; a1 = 2'd0; a2 = 2'd1;
      expect_val("pre_e0", S_BP_D1, 'hF);
      expect_val("pre_e1", S_BP_D2, 'hF);
      cyc();
      a1 = 2'd2; a2 = 2'd3; clr = 1'b1;
      expect_val("pre_e2", S_BP_D1, 'hF);
      expect_val("pre_e3", S_BP_D2, 'hF);
      expect_val("pre_busy", S_BP_BUSY, 0);
      cyc();
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         we3 = 1'b1; a3 = 2'd3; d3 = 4'h7; we4 = 1'b1; a4 = 2'd3; d4 = 4'h7;
         a1 = 2'(i); a2 = 2'd0;
         expect_val("clr_busy", S_BP_BUSY, 1);
         expect_val("clr_nb_busy", S_NB_BUSY, 1);
         expect_val("clr_cur", S_BP_D1, 'hF);
         expect_val("clr_e0", S_BP_D2, (i == 0) ? 'hF : 0);
         expect_val("clr_nocoll", S_BP_COLL, 0);
         cyc();
      end
      we3 = 1'b0; we4 = 1'b0; a1 = 2'd3; a2 = 2'd2;
      expect_val("clr_end_busy", S_BP_BUSY, 0);
      expect_val("clr_lost_wr", S_BP_D1, 0);
      expect_val("clr_e2", S_BP_D2, 0);
      expect_val("clr_end_coll", S_BP_COLL, 0);
      cyc();

      // Writes on the clr edge land, then reset mid-clear aborts everything.
      we3 = 1'b1; a3 = 2'd1; d3 = 4'hC; we4 = 1'b1; a4 = 2'd3; d4 = 4'hE; clr = 1'b1;
      a1 = 2'd1; a2 = 2'd3;
      expect_val("clrw_byp", S_BP_D1, 'hC);
      cyc();
      we3 = 1'b0; we4 = 1'b0; clr = 1'b0;
      expect_val("clrw_done", S_BP_D1, 'hC);
      expect_val("clrw_e3", S_BP_D2, 'hE);
      expect_val("clrw_busy0", S_BP_BUSY, 1);
      cyc();
      expect_val("clrw_busy1", S_BP_BUSY, 1);
      cyc();
      expect_val("clrw_busy2", S_BP_BUSY, 1);
      expect_val("clrw_e1_gone", S_BP_D1, 0);
      expect_val("clrw_e3_held", S_BP_D2, 'hE);
      @(negedge clk);
      drain();
      #2;
      rst_n = 1'b0;
      #1;
      expect_val("midrst_busy", S_BP_BUSY, 0);
      expect_val("midrst_nb_busy", S_NB_BUSY, 0);
      expect_val("midrst_e3", S_BP_D2, 0);
      expect_val("midrst_coll", S_BP_COLL, 0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bp_busy) busy_cnt++;
      end
      expect_val("rerun_busy_cycles", S_CNT, 4);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised register file with two combinational read ports and two synchronous write ports. Compared with the single-write-port register file, it adds asynchronous reset-to-zero, optional same-cycle write-to-read bypass, and an optional hardwired-zero register 0. It also has a sequential clear engine that zeroes the whole array on request, one entry per cycle. It sits in the datapath as the general-purpose register bank between decode (addresses) and the ALU (operands).

## Interface
- N, default 2: address width; depth is 2**N entries.
- M, default 4: data width in bits.
- BYPASS, default 1: 1 enables write-to-read forwarding; 0 means reads return stored contents only.
- ZERO_REG, default 0: 1 makes entry 0 read as zero and ignore writes.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we3  in  1  write enable, port 3.
- a3  in  N  write address, port 3.
- d3  in  M  write data, port 3.
- we4  in  1  write enable, port 4.
- a4  in  N  write address, port 4.
- d4  in  M  write data, port 4.
- a1, a2  in  N  read addresses.
- d1, d2  out  M  read data, combinational.
- clr  in  1  start the clear engine; level-sampled at the clock edge.
- busy  out  1  high while the clear engine runs.
- coll  out  1  registered flag: both write ports targeted the same entry in the previous cycle.

## Operation
- Reset (rst_n=0, immediate, no clock needed):
  - all entries = 0;
  - FSM = IDLE, clear counter = 0;
  - busy=0, coll=0.
- FSM states and transitions:
  - IDLE: on clr=1, go to CLEAR with counter=0.
  - CLEAR: each cycle write 0 to mem[counter], then counter+1.
  - When counter = 2**N-1, that entry is cleared and the FSM returns to IDLE.
  - busy = (state==CLEAR).
- Writes in IDLE:
  - we3 writes d3 to mem[a3]; we4 writes d4 to mem[a4].
  - Same address on both ports: port 3 wins, d4 is dropped, and coll=1 the next cycle.
  - coll is 0 in every other cycle.
- Writes in CLEAR:
  - we3/we4 are ignored and dropped; no collision is flagged.
  - clr is ignored.
- clr=1 on the same edge as writes in IDLE: the writes are performed on that edge, then clearing starts next cycle, so the writes are eventually overwritten.
- Reads, d1 (d2 identical with a2):
  - ZERO_REG=1 and a1=0: d1=0.
  - Else, if BYPASS=1, IDLE, and we3 && a3==a1: d1=d3.
  - Else, if BYPASS=1, IDLE, and we4 && a4==a1 && !(we3 && a3==a4): d1=d4.
  - Else d1=mem[a1].
- No bypass during CLEAR: reads return current contents, which may be partially cleared.
- ZERO_REG=1:
  - writes to entry 0 are discarded;
  - collision on address 0 is not flagged;
  - the clear engine still steps through entry 0 (harmless).
- Counter is N bits wide and wraps naturally; the terminal check is on 2**N-1, not on overflow.

## Timing
- Write latency: data is visible from storage on the cycle after the edge.
- With BYPASS=1 it is visible the same cycle, combinationally.
- Read latency: 0 cycles, combinational from address.
- Clear duration: exactly 2**N cycles with busy=1.
- busy rises on the edge that samples clr=1 and falls on the edge that writes the last entry.
- The first write accepted after clear is on the edge where busy is already 0.
- coll: one cycle after the colliding edge; a single-cycle pulse per colliding cycle.
- Reset asserted mid-clear aborts immediately: all entries 0, IDLE, busy=0.
- rst_n deassertion is synchronised externally; the block must not update on the edge coincident with deassertion.

## Test plan
All scenarios use N=2, M=4 unless stated.
- Reset, then reads: rst_n=0 asynchronously, with all a1 values swept -> d1=d2=0, busy=0, coll=0.
- Write then read, BYPASS=0: we3=1, a3=2, d3=4'hA on edge k; a1=2 -> d1=0 during cycle k, 4'hA after edge k.
- Bypass, BYPASS=1:
  - we4=1, a4=1, d4=4'h5, a2=1 -> d2=4'h5 in the same cycle;
  - add we3=1, a3=1, d3=4'h3 -> d2=4'h3;
  - coll=1 next cycle, and mem[1]=4'h3 afterwards.
- Clear engine:
  - preload all 4 entries with 4'hF, pulse clr -> busy high exactly 4 cycles;
  - mem[0..3] read 0 in sequence;
  - we3 writes of 4'h7 during busy are lost.
- ZERO_REG=1: we3=1, a3=0, d3=4'h9 -> d1 (a1=0)=0 in the same cycle and later; no coll when we4 also targets 0.
- Reset mid-clear: assert rst_n=0 at cycle 2 of CLEAR -> busy=0 immediately; after release, a new clr runs a full 4 cycles.
